keypad_decoder: RTL and testbench

//  Consumer of the 16-bit raw key map produced by the matrix keypad scanner.

---
 rtl/keypad_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder.sv
// keypad_decoder: debounces the 16 CHIP-8 hex keys from the matrix scanner,
// exports the stable key map, and runs the FX0A wait-for-key handshake
// (one press followed by the release of that same key).
// Optional press/release event queue: define KEYPAD_DECODER_EVENTS_EN.
// Without it, evt_valid/evt_key/evt_press/evt_ovf are tied to 0 and evt_ready is ignored.
//
// Handshake: the head event transfers on any clock edge where evt_valid && evt_ready.
// evt_key/evt_press stay stable while evt_valid && !evt_ready.
// A push into an empty FIFO appears on evt_valid one cycle later; there is no bypass path.
module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] raw_keys,
  input  logic        sample_en,
  output logic [15:0] key_state,
  input  logic        wait_req,
  output logic        wait_ack,
  output logic [3:0]  wait_key,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic        evt_ovf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // A disagreeing sample that arrives while the counter holds this value flips the key.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HELD, S_ACK} wait_state_t;

  logic [CW-1:0] cnt_q [16];
  logic [CW-1:0] cnt_d [16];
  logic [15:0]   state_d;
  logic [15:0]   press_edge;
  logic [15:0]   rel_edge;
  wait_state_t   wait_state;
  logic [3:0]    held_key;
  logic [3:0]    first_press;

  // Per-key debounce: next counter value, next key state, and this cycle's flip edges.
  always_comb begin
    state_d    = key_state;
    press_edge = '0;
    rel_edge   = '0;
    for (int n = 0; n < 16; n++) begin
      cnt_d[n] = cnt_q[n];
      if (sample_en) begin
        if (raw_keys[n] != key_state[n]) begin
          if (cnt_q[n] == CNT_LAST) begin
            cnt_d[n]      = '0;
            state_d[n]    = raw_keys[n];
            press_edge[n] = raw_keys[n];
            rel_edge[n]   = ~raw_keys[n];
          end else begin
            cnt_d[n] = cnt_q[n] + CW'(1);
          end
        end else begin
          cnt_d[n] = '0;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_state <= '0;
      for (int n = 0; n < 16; n++) cnt_q[n] <= '0;
    end else begin
      key_state <= state_d;
      for (int n = 0; n < 16; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Select the lowest-index key that has a press edge this cycle.
  always_comb begin
    first_press = '0;
    for (int n = 15; n >= 0; n--) begin
      if (press_edge[n]) first_press = 4'(n);
    end
  end

  // FX0A handshake FSM. Keys that were already down when the FSM armed produce no
  // press edge, so they are ignored until they are released and pressed again.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_state <= S_IDLE;
      held_key   <= '0;
      wait_ack   <= 1'b0;
      wait_key   <= '0;
    end else begin
      wait_ack <= 1'b0;
      case (wait_state)
        S_IDLE: begin
          if (wait_req) wait_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!wait_req) begin
            wait_state <= S_IDLE;
          end else if (|press_edge) begin
            wait_state <= S_HELD;
            held_key   <= first_press;
          end
        end
        S_HELD: begin
          if (!wait_req) begin
            wait_state <= S_IDLE;
          end else if (rel_edge[held_key]) begin
            wait_state <= S_ACK;
            wait_ack   <= 1'b1;
            wait_key   <= held_key;
          end
        end
        S_ACK:   wait_state <= S_IDLE;
        default: wait_state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_DECODER_EVENTS_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [15:0]   press_pend;
  logic [15:0]   rel_pend;
  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          found;
  logic          push;
  logic          pop;
  logic          push_press;
  logic [3:0]    push_key;
  logic [15:0]   press_clr;
  logic [15:0]   rel_clr;

  // Pick the next pending event: lowest index first; a press goes before a release at the same index.
  always_comb begin
    found      = 1'b0;
    push_key   = '0;
    push_press = 1'b0;
    for (int n = 15; n >= 0; n--) begin
      if (press_pend[n] || rel_pend[n]) begin
        found      = 1'b1;
        push_key   = 4'(n);
        push_press = press_pend[n];
      end
    end
    pop       = evt_valid && evt_ready;
    push      = found && ((fifo_cnt != FULL_CNT) || pop);
    press_clr = (push && push_press)  ? (16'd1 << push_key) : 16'd0;
    rel_clr   = (push && !push_press) ? (16'd1 << push_key) : 16'd0;
  end

  // Pending vectors, overflow flag, and FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      press_pend <= '0;
      rel_pend   <= '0;
      evt_ovf    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      press_pend <= (press_pend & ~press_clr) | press_edge;
      rel_pend   <= (rel_pend & ~rel_clr) | rel_edge;
      if ((|(press_edge & press_pend & ~press_clr)) || (|(rel_edge & rel_pend & ~rel_clr)))
        evt_ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage (contents are don't-care while empty, so this array has no reset).
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= {push_press, push_key};
  end

  assign evt_valid            = (fifo_cnt != '0);
  assign {evt_press, evt_key} = fifo_mem[rd_ptr];
`else
  logic unused_evt;
  assign unused_evt = evt_ready & (FIFO_DEPTH >= 2);
  assign evt_valid  = 1'b0;
  assign evt_key    = 4'd0;
  assign evt_press  = 1'b0;
  assign evt_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder. Expected events and FX0A acks are queued when stimulus
// is driven; monitors pop and compare them when the DUT presents them.
module tb_keypad_decoder;

  logic        clk_in;
  logic        rst_in;
  logic [15:0] raw_keys;
  logic        sample_en;
  logic [15:0] key_state;
  logic        wait_req;
  logic        wait_ack;
  logic [3:0]  wait_key;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic        evt_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_count = 0;

  logic [4:0] exp_q[$];
  logic [3:0] wait_q[$];
  logic [4:0] mon_e;
  logic [3:0] mon_k;

  keypad_decoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .raw_keys  (raw_keys),
    .sample_en (sample_en),
    .key_state (key_state),
    .wait_req  (wait_req),
    .wait_ack  (wait_ack),
    .wait_key  (wait_key),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_press (evt_press),
    .evt_ovf   (evt_ovf)
  );

  // Clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // n samples of one raw pattern, each as a one-cycle sample_en strobe followed by an idle cycle.
  task automatic scan(input logic [15:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      raw_keys  = raw;
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      step();
    end
  endtask

  task automatic exp_evt(input logic press, input logic [3:0] key);
`ifdef KEYPAD_DECODER_EVENTS_EN
    exp_q.push_back({press, key});
`endif
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
    check("drain_exp_q_size", exp_q.size(), 0);
  endtask

  // Event and ack monitors, sampled on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (!rst_in && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected_qsize", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_head", {27'd0, evt_press, evt_key}, {27'd0, mon_e});
      end
    end
    if (!rst_in && wait_ack) begin
      ack_count++;
      if (wait_q.size() == 0) begin
        check("ack_unexpected_qsize", wait_q.size(), 1);
      end else begin
        mon_k = wait_q.pop_front();
        check("ack_wait_key", {28'd0, wait_key}, {28'd0, mon_k});
      end
    end
  end

  initial begin
    rst_in    = 1'b1;
    raw_keys  = '0;
    sample_en = 1'b0;
    wait_req  = 1'b0;
    evt_ready = 1'b1;
    repeat (3) step();
    rst_in = 1'b0;

    // Reset values.
    check("rst_key_state", {16'd0, key_state}, 0);
    check("rst_wait_ack", {31'd0, wait_ack}, 0);
    check("rst_wait_key", {28'd0, wait_key}, 0);
    check("rst_evt_valid", {31'd0, evt_valid}, 0);
    check("rst_evt_ovf", {31'd0, evt_ovf}, 0);

    // Key 5 held, sample every 4th cycle: flips right after the 4th sample.
    raw_keys = 16'h0020;
    for (int s = 1; s <= 4; s++) begin
      repeat (3) step();
      if (s == 4) exp_evt(1'b1, 4'h5);
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      if (s == 3) check("t1_before_4th", {16'd0, key_state}, 0);
    end
    check("t1_after_4th", {16'd0, key_state}, 32'h0020);
    exp_evt(1'b0, 4'h5);
    scan(16'h0000, 4);
    check("t1_released", {16'd0, key_state}, 0);
    drain(20);

    // Interrupted run restarts the count: 1,1,0,1,1,1,1.
    scan(16'h0008, 2);
    scan(16'h0000, 1);
    scan(16'h0008, 3);
    check("t2_after_6th", {31'd0, key_state[3]}, 0);
    exp_evt(1'b1, 4'h3);
    scan(16'h0008, 1);
    check("t2_after_7th", {31'd0, key_state[3]}, 1);
    exp_evt(1'b0, 4'h3);
    scan(16'h0000, 4);
    drain(20);

    // Key 7 already held when armed must never be reported.
    exp_evt(1'b1, 4'h7);
    scan(16'h0080, 4);
    wait_req = 1'b1;
    repeat (2) step();
    exp_evt(1'b0, 4'h7);
    scan(16'h0000, 4);
    exp_evt(1'b1, 4'hA);
    scan(16'h0400, 4);
    wait_q.push_back(4'hA);
    exp_evt(1'b0, 4'hA);
    scan(16'h0000, 4);
    repeat (3) step();
    wait_req = 1'b0;
    repeat (3) step();
    check("t3_wait_key_holds", {28'd0, wait_key}, 32'hA);
    check("t3_ack_count", ack_count, 1);
    drain(20);

    // Keys 2 and 9 in the same sample: key 2 is captured; releasing 9 must not ack.
    wait_req = 1'b1;
    repeat (2) step();
    exp_evt(1'b1, 4'h2);
    exp_evt(1'b1, 4'h9);
    scan(16'h0204, 4);
    exp_evt(1'b0, 4'h9);
    scan(16'h0004, 4);
    check("t4_no_ack_on_9", ack_count, 1);
    wait_q.push_back(4'h2);
    exp_evt(1'b0, 4'h2);
    scan(16'h0000, 4);
    repeat (3) step();
    wait_req = 1'b0;
    check("t4_ack_count", ack_count, 2);
    drain(20);

`ifdef KEYPAD_DECODER_EVENTS_EN
    // Six press edges with a stalled consumer: 4 queued, 2 pending, head stable.
    evt_ready = 1'b0;
    exp_evt(1'b1, 4'h0);
    exp_evt(1'b1, 4'h1);
    exp_evt(1'b1, 4'h2);
    scan(16'h0007, 4);
    exp_evt(1'b1, 4'h4);
    exp_evt(1'b1, 4'h5);
    exp_evt(1'b1, 4'h6);
    scan(16'h0077, 4);
    repeat (4) step();
    check("t5_valid_stalled", {31'd0, evt_valid}, 1);
    check("t5_head_stalled", {27'd0, evt_press, evt_key}, 32'h10);
    repeat (3) step();
    check("t5_head_holds", {27'd0, evt_press, evt_key}, 32'h10);
    evt_ready = 1'b1;
    drain(30);
    check("t5_ovf_clear", {31'd0, evt_ovf}, 0);
    step();
    check("t5_empty", {31'd0, evt_valid}, 0);
    exp_evt(1'b0, 4'h0);
    exp_evt(1'b0, 4'h1);
    exp_evt(1'b0, 4'h2);
    exp_evt(1'b0, 4'h4);
    exp_evt(1'b0, 4'h5);
    exp_evt(1'b0, 4'h6);
    scan(16'h0000, 4);
    drain(30);

    // Repeat press on a key whose press is still pending merges and sets evt_ovf.
    evt_ready = 1'b0;
    exp_evt(1'b1, 4'h0);
    exp_evt(1'b1, 4'h1);
    exp_evt(1'b1, 4'h2);
    exp_evt(1'b1, 4'h4);
    scan(16'h0017, 4);
    exp_evt(1'b1, 4'h5);
    scan(16'h0037, 4);
    exp_evt(1'b0, 4'h5);
    scan(16'h0017, 4);
    check("t5_ovf_before_merge", {31'd0, evt_ovf}, 0);
    scan(16'h0037, 4);
    check("t5_ovf_after_merge", {31'd0, evt_ovf}, 1);
    evt_ready = 1'b1;
    drain(30);
    exp_evt(1'b0, 4'h0);
    exp_evt(1'b0, 4'h1);
    exp_evt(1'b0, 4'h2);
    exp_evt(1'b0, 4'h4);
    exp_evt(1'b0, 4'h5);
    scan(16'h0000, 4);
    drain(30);
    check("t5_ovf_sticky", {31'd0, evt_ovf}, 1);
`else
    // Event outputs stay at zero whatever the consumer and keys do.
    evt_ready = 1'b0;
    scan(16'h0011, 4);
    check("t5_off_valid", {31'd0, evt_valid}, 0);
    evt_ready = 1'b1;
    scan(16'h0000, 4);
    check("t5_off_key_press", {27'd0, evt_press, evt_key}, 0);
    check("t5_off_ovf", {31'd0, evt_ovf}, 0);
`endif

    // Reset while the FSM is in HELD: everything clears, no ack follows.
    wait_req = 1'b1;
    repeat (2) step();
    exp_evt(1'b1, 4'hC);
    scan(16'h1000, 4);
    repeat (4) step();
    check("t6_held_key_state", {16'd0, key_state}, 32'h1000);
    rst_in = 1'b1;
    repeat (2) step();
    rst_in = 1'b0;
    check("t6_key_state", {16'd0, key_state}, 0);
    check("t6_evt_valid", {31'd0, evt_valid}, 0);
    check("t6_evt_ovf", {31'd0, evt_ovf}, 0);
    check("t6_wait_ack", {31'd0, wait_ack}, 0);
    scan(16'h0000, 4);
    repeat (4) step();
    check("t6_wait_ack_later", {31'd0, wait_ack}, 0);
    wait_req = 1'b0;
    repeat (2) step();

    check("end_exp_q_size", exp_q.size(), 0);
    check("end_wait_q_size", wait_q.size(), 0);
    check("end_ack_count", ack_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
